// File: rtl/move_sequencer.sv
// move_sequencer: turn controller between two players' column buttons and a Connect-4 core.
// Arms on release, validates the owner's press, auto-plays on timeout, then waits for the core's ack.

module move_col_chk #(
  parameter int ROWS = 4
) (
  input  logic [2:0] count,
  input  logic       btn_n,
  output logic       full,
  output logic       hit
);
  assign full = (int'(count) >= ROWS);
  assign hit  = ~btn_n;
endmodule

module move_sequencer #(
  parameter int ROWS         = 4,
  parameter int TURN_TIMEOUT = 1000,
  parameter int ACK_TIMEOUT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] p1_buttons,
  input  logic [3:0] p2_buttons,
  input  logic [2:0] counter_0,
  input  logic [2:0] counter_1,
  input  logic [2:0] counter_2,
  input  logic [2:0] counter_3,
  input  logic [1:0] game_status,
  output logic       enable,
  output logic [3:0] in_column,
  output logic       turn,
  output logic       reject,
  output logic       timeout_flag,
  output logic       fault,
  output logic [4:0] move_count,
  output logic [2:0] state
);
  localparam int NUM_COLS = 4;
  localparam int TW = $clog2(TURN_TIMEOUT + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_WAIT_INPUT = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_ACK   = 3'd2,
    S_SETTLE     = 3'd3,
    S_GAME_OVER  = 3'd4,
    S_FAULT      = 3'd5
  } state_t;

  state_t                   st, st_nxt;
  logic [NUM_COLS-1:0][2:0] cnt;
  logic [3:0]               p1_q, p2_q, own_q;
  logic [NUM_COLS-1:0]      col_full, col_hit;
  logic                     armed;
  logic [TW-1:0]            turn_tmr;
  logic [AW-1:0]            ack_tmr;
  logic [1:0]               sel, press_idx, auto_idx;
  logic [2:0]               cap;
  logic                     one_hot, any_hit, any_free, timer_hit, consider, valid_press;
  logic                     take_press, take_auto, rej, ack, toggle;

  assign cnt   = {counter_3, counter_2, counter_1, counter_0};
  assign own_q = turn ? p2_q : p1_q;

  generate
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      move_col_chk #(.ROWS(ROWS)) u_chk (
        .count (cnt[c]),
        .btn_n (own_q[c]),
        .full  (col_full[c]),
        .hit   (col_hit[c])
      );
    end
  endgenerate

  // Descending scan leaves the lowest matching index in each result
  always_comb begin
    press_idx = '0;
    auto_idx  = '0;
    any_free  = 1'b0;
    for (int c = NUM_COLS - 1; c >= 0; c--) begin
      if (col_hit[c]) press_idx = 2'(c);
      if (!col_full[c]) begin
        auto_idx = 2'(c);
        any_free = 1'b1;
      end
    end
  end

  assign any_hit     = |col_hit;
  assign one_hot     = any_hit && ((col_hit & (col_hit - 4'd1)) == 4'd0);
  assign timer_hit   = (turn_tmr == TW'(TURN_TIMEOUT - 1));
  assign consider    = (st == S_WAIT_INPUT) && armed && any_hit;
  assign valid_press = consider && one_hot && !col_full[press_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_WAIT_INPUT;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt     = st;
    take_press = 1'b0;
    take_auto  = 1'b0;
    rej        = 1'b0;
    ack        = 1'b0;
    toggle     = 1'b0;
    case (st)
      S_WAIT_INPUT: begin
        // A valid press beats a simultaneous timeout
        if (valid_press) begin
          take_press = 1'b1;
          st_nxt     = S_ISSUE;
        end else begin
          rej = consider;
          if (timer_hit && any_free) begin
            take_auto = 1'b1;
            st_nxt    = S_ISSUE;
          end
        end
      end
      S_ISSUE: st_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (cnt[sel] != cap) begin
          ack    = 1'b1;
          st_nxt = S_SETTLE;
        end else if (ack_tmr == AW'(ACK_TIMEOUT - 1)) begin
          st_nxt = S_FAULT;
        end
      end
      S_SETTLE: begin
        if (game_status != 2'b00 || move_count == 5'd16) begin
          st_nxt = S_GAME_OVER;
        end else begin
          toggle = 1'b1;
          st_nxt = S_WAIT_INPUT;
        end
      end
      S_GAME_OVER, S_FAULT: st_nxt = st;
      default: st_nxt = S_WAIT_INPUT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_q         <= 4'hF;
      p2_q         <= 4'hF;
      armed        <= 1'b1;
      turn_tmr     <= '0;
      ack_tmr      <= '0;
      sel          <= '0;
      cap          <= '0;
      move_count   <= '0;
      turn         <= 1'b0;
      reject       <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      p1_q <= p1_buttons;
      p2_q <= p2_buttons;
      if (own_q == 4'hF) armed <= 1'b1;
      else if (consider) armed <= 1'b0;
      turn_tmr <= (st != S_WAIT_INPUT) ? '0 : (timer_hit ? turn_tmr : turn_tmr + TW'(1));
      ack_tmr  <= (st != S_WAIT_ACK) ? '0 : ack_tmr + AW'(1);
      if (take_press) begin
        sel <= press_idx;
        cap <= cnt[press_idx];
      end else if (take_auto) begin
        sel <= auto_idx;
        cap <= cnt[auto_idx];
      end
      if (ack && move_count != 5'd16) move_count <= move_count + 5'd1;
      if (toggle) turn <= ~turn;
      reject       <= rej;
      timeout_flag <= take_auto;
    end
  end

  assign enable    = (st == S_ISSUE);
  assign in_column = (st == S_ISSUE || st == S_WAIT_ACK || st == S_SETTLE) ? ~(4'b0001 << sel) : 4'hF;
  assign fault     = (st == S_FAULT);
  assign state     = st;
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a behavioural core model and an in_column scoreboard.

module tb_move_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] p1, p2;
  logic [1:0] game_status;
  logic       enable, turn, reject, timeout_flag, fault;
  logic [3:0] in_column;
  logic [4:0] move_count;
  logic [2:0] state;
  logic [2:0] counter_0, counter_1, counter_2, counter_3;

  logic [3:0][2:0] base = '0;
  logic [3:0][2:0] inc  = '0;
  logic            clr_inc = 1'b0;
  logic            core_ack = 1'b1;

  int n_chk = 0, n_pass = 0, n_en = 0, n_rej = 0, n_to = 0;
  logic [3:0] exp_q[$];

  move_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .p1_buttons   (p1),
    .p2_buttons   (p2),
    .counter_0    (counter_0),
    .counter_1    (counter_1),
    .counter_2    (counter_2),
    .counter_3    (counter_3),
    .game_status  (game_status),
    .enable       (enable),
    .in_column    (in_column),
    .turn         (turn),
    .reject       (reject),
    .timeout_flag (timeout_flag),
    .fault        (fault),
    .move_count   (move_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  assign counter_0 = base[0] + inc[0];
  assign counter_1 = base[1] + inc[1];
  assign counter_2 = base[2] + inc[2];
  assign counter_3 = base[3] + inc[3];

  // Core model: drop a piece into the strobed column one edge after enable
  always @(posedge clk) begin
    if (clr_inc) inc <= '0;
    else if (enable && core_ack)
      for (int c = 0; c < 4; c++) if (!in_column[c]) inc[c] <= inc[c] + 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (reject) n_rej++;
    if (timeout_flag) n_to++;
    if (enable) begin
      n_en++;
      if (exp_q.size() == 0) chk("unexpected_enable", 32'd1, 32'd0);
      else chk("in_column", {28'd0, in_column}, {28'd0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_cols(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
    clr_inc = 1'b1;
    base    = {d, c, b, a};
    tick();
    clr_inc = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, {29'd0, state}, 32'd0);
    chk({tag, "_turn"}, {31'd0, turn}, 32'd0);
    chk({tag, "_in_column"}, {28'd0, in_column}, 32'hF);
    chk({tag, "_enable"}, {31'd0, enable}, 32'd0);
    chk({tag, "_reject"}, {31'd0, reject}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout_flag}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_move_count"}, {27'd0, move_count}, 32'd0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      if (state == 3'd0 || state == 3'd4) break;
      tick();
    end
  endtask

  task automatic move(input bit p, input int c);
    logic [3:0] v;
    v    = 4'hF;
    v[c] = 1'b0;
    chk("turn_before_move", {31'd0, turn}, {31'd0, p});
    exp_q.push_back(v);
    if (p) p2 = v;
    else   p1 = v;
    tick();
    tick();
    p1 = 4'hF;
    p2 = 4'hF;
    wait_idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    p1 = 4'hF;
    p2 = 4'hF;
    game_status = 2'b00;
    set_cols(0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int en0, rej0, to0;
    reset = 1'b1;
    p1 = 4'hF;
    p2 = 4'hF;
    game_status = 2'b00;
    tick();
    chk_reset_outputs("reset");
    do_reset();

    // First P1 move into column 0
    en0 = n_en;
    move(1'b0, 0);
    chk("m1_enables", n_en - en0, 1);
    chk("m1_move_count", {27'd0, move_count}, 1);
    chk("m1_turn", {31'd0, turn}, 1);
    chk("m1_state", {29'd0, state}, 0);

    // P2's turn: P1 ignored, P2 multi-bit rejected, P2 held press gives one move
    en0 = n_en; rej0 = n_rej;
    p1 = 4'b1101;
    repeat (5) tick();
    p1 = 4'hF;
    repeat (3) tick();
    chk("wrong_player_enable", n_en - en0, 0);
    chk("wrong_player_reject", n_rej - rej0, 0);
    p2 = 4'b1001;
    repeat (4) tick();
    p2 = 4'hF;
    repeat (3) tick();
    chk("multi_bit_reject", n_rej - rej0, 1);
    chk("multi_bit_enable", n_en - en0, 0);
    exp_q.push_back(4'b1101);
    p2 = 4'b1101;
    repeat (50) tick();
    p2 = 4'hF;
    repeat (3) tick();
    chk("held_enable_count", n_en - en0, 1);
    chk("held_reject_count", n_rej - rej0, 1);
    chk("held_move_count", {27'd0, move_count}, 2);
    chk("held_turn", {31'd0, turn}, 0);

    // Full column press
    set_cols(1, 1, 4, 0);
    en0 = n_en; rej0 = n_rej;
    p1 = 4'b1011;
    repeat (3) tick();
    p1 = 4'hF;
    repeat (3) tick();
    chk("full_col_reject", n_rej - rej0, 1);
    chk("full_col_enable", n_en - en0, 0);
    chk("full_col_turn", {31'd0, turn}, 0);

    // Auto-move skips full column 0
    set_cols(4, 2, 4, 0);
    en0 = n_en; to0 = n_to;
    exp_q.push_back(4'b1101);
    for (int k = 0; k < 1200 && n_to == to0; k++) tick();
    wait_idle();
    chk("timeout_pulses", n_to - to0, 1);
    chk("timeout_enable", n_en - en0, 1);
    chk("timeout_turn", {31'd0, turn}, 1);
    chk("timeout_move_count", {27'd0, move_count}, 3);

    // Seven-move P1 win in column 0
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 6) game_status = 2'b01;
      move(i[0], i[0] ? 1 : 0);
    end
    chk("win_state", {29'd0, state}, 4);
    chk("win_move_count", {27'd0, move_count}, 7);
    en0 = n_en; rej0 = n_rej;
    p1 = 4'b1110;
    repeat (4) tick();
    p1 = 4'hF;
    p2 = 4'b0111;
    repeat (4) tick();
    p2 = 4'hF;
    repeat (2) tick();
    chk("game_over_enable", n_en - en0, 0);
    chk("game_over_reject", n_rej - rej0, 0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("post_win_reset");

    // Core never acks
    do_reset();
    core_ack = 1'b0;
    exp_q.push_back(4'b1110);
    p1 = 4'b1110;
    for (int k = 0; k < 10 && state != 3'd1; k++) tick();
    chk("fault_issue", {29'd0, state}, 1);
    p1 = 4'hF;
    repeat (8) tick();
    chk("fault_still_waiting", {29'd0, state}, 2);
    tick();
    chk("fault_state", {29'd0, state}, 5);
    chk("fault_flag", {31'd0, fault}, 1);
    chk("fault_in_column", {28'd0, in_column}, 32'hF);

    // Reset asserted while waiting for ack
    do_reset();
    exp_q.push_back(4'b1110);
    p1 = 4'b1110;
    for (int k = 0; k < 10 && state != 3'd2; k++) tick();
    chk("midmove_wait_ack", {29'd0, state}, 2);
    reset = 1'b1;
    p1 = 4'hF;
    #1;
    chk_reset_outputs("midmove_reset");
    en0 = n_en;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    chk("midmove_no_enable", n_en - en0, 0);

    // Sixteen-move tie fills every column
    core_ack = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) move(i[0], i / 4);
    chk("tie_state", {29'd0, state}, 4);
    chk("tie_move_count", {27'd0, move_count}, 16);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
